// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data ports.
// Grant in IDLE, MEM_LAT enabled cycles in ACCESS, one-cycle valid pulse in RESP; all outputs registered.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic       OWN_I = 1'b0;
  localparam logic       OWN_D = 1'b1;
  localparam logic [3:0] LAT   = 4'(MEM_LAT);

  state_t            state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [3:0]        cnt_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              owner_d;

  // On a tie the requester that did not win last time gets the memory.
  always_comb begin
    owner_d = OWN_I;
    if (d_req && (!i_req || last_grant_q == OWN_I)) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_D;
      cnt_q        <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner_q      <= owner_d;
            last_grant_q <= owner_d;
            mem_addr_q   <= (owner_d == OWN_D) ? d_addr : i_addr;
            mem_wdata_q  <= (owner_d == OWN_D) ? d_wdata : '0;
            mem_we_q     <= (owner_d == OWN_D) && d_we;
            mem_en_q     <= 1'b1;
            cnt_q        <= 4'd1;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAT) begin
            // Read data is only valid in the last enabled cycle; writes keep d_rdata.
            if (owner_q == OWN_I) begin
              i_rdata_q <= mem_rdata;
            end else if (!mem_we_q) begin
              d_rdata_q <= mem_rdata;
            end
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            i_valid_q <= (owner_q == OWN_I);
            d_valid_q <= (owner_q == OWN_D);
            state_q   <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign i_valid   = i_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MEM_LAT=2 instance with a small memory model and a MEM_LAT=1 instance.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_valid, d_valid, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:31] = '{4: 32'hDEADBEEF, default: 32'h0};
  assign mem_rdata = mem_en ? mem[mem_addr[6:2]] : 32'h0;
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[6:2]] <= mem_wdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // MEM_LAT=1 instance; its memory returns 0xA5000000 | address
  logic        l_i_req = 1'b0, l_d_req = 1'b0, l_d_we = 1'b0;
  logic [31:0] l_i_addr = '0, l_d_addr = '0, l_d_wdata = '0;
  logic        l_i_valid, l_d_valid, l_mem_en, l_mem_we;
  logic [31:0] l_i_rdata, l_d_rdata, l_mem_addr, l_mem_wdata, l_mem_rdata;
  assign l_mem_rdata = l_mem_en ? (32'hA500_0000 | l_mem_addr) : 32'h0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(l_i_req), .i_addr(l_i_addr), .i_valid(l_i_valid), .i_rdata(l_i_rdata),
    .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
    .d_valid(l_d_valid), .d_rdata(l_d_rdata),
    .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr),
    .mem_wdata(l_mem_wdata), .mem_rdata(l_mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    checks++;
    if ({i_valid, d_valid, mem_en, mem_we} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {i_valid, d_valid, mem_en, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    checks++;
    if ({l_i_valid, l_d_valid, l_mem_en, l_mem_we} !== 4'b0) begin
      errors++; $display("FAIL reset_lat1: got %b expected 0000", {l_i_valid, l_d_valid, l_mem_en, l_mem_we});
    end
    rst = 1'b0;
    step;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++; $display("FAIL reset_idle_mem_en: got %b expected 0", mem_en);
    end
  endtask

  task automatic test_fetch;
    i_req = 1'b1; i_addr = 32'h10;
    for (int c = 1; c <= 4; c++) begin
      step;
      checks++;
      if (mem_en !== (c == 1 || c == 2)) begin
        errors++; $display("FAIL fetch_mem_en c%0d: got %b expected %b", c, mem_en, (c == 1 || c == 2));
      end
      if (c <= 2) begin
        checks++;
        if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
          errors++; $display("FAIL fetch_addr c%0d: got %h/%b expected 00000010/0", c, mem_addr, mem_we);
        end
      end
      checks++;
      if (i_valid !== (c == 3) || d_valid !== 1'b0) begin
        errors++; $display("FAIL fetch_valid c%0d: got i=%b d=%b expected i=%b d=0", c, i_valid, d_valid, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (i_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL fetch_rdata: got %h expected deadbeef", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_write_read;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
    for (int c = 1; c <= 4; c++) begin
      step;
      if (c <= 2) begin
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h12345678) begin
          errors++; $display("FAIL write_mem c%0d: got en=%b we=%b a=%h wd=%h expected 1 1 00000040 12345678",
                             c, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      checks++;
      if (d_valid !== (c == 3) || i_valid !== 1'b0) begin
        errors++; $display("FAIL write_valid c%0d: got d=%b i=%b expected d=%b i=0", c, d_valid, i_valid, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (d_rdata !== 32'h0 || mem_we !== 1'b0) begin
          errors++; $display("FAIL write_rdata_kept: got %h we=%b expected 00000000 we=0", d_rdata, mem_we);
        end
        d_req = 1'b0;
      end
    end
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      step;
      checks++;
      if (mem_en !== (c == 1 || c == 2) || d_valid !== (c == 3)) begin
        errors++; $display("FAIL read_timing c%0d: got en=%b dv=%b expected en=%b dv=%b",
                           c, mem_en, d_valid, (c == 1 || c == 2), (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (d_rdata !== 32'h12345678) begin
          errors++; $display("FAIL read_back: got %h expected 12345678", d_rdata);
        end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_tie;
    rst = 1'b1; step; rst = 1'b0; step;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      step;
      checks++;
      if (i_valid !== (c == 3 || c == 11) || d_valid !== (c == 7)) begin
        errors++; $display("FAIL tie_order c%0d: got i=%b d=%b expected i=%b d=%b",
                           c, i_valid, d_valid, (c == 3 || c == 11), (c == 7));
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (mem_addr !== 32'h40 || mem_en !== 1'b1) begin
          errors++; $display("FAIL tie_d_addr c%0d: got %h en=%b expected 00000040 en=1", c, mem_addr, mem_en);
        end
      end
      if (c == 7) begin
        checks++;
        if (d_rdata !== 32'h12345678) begin
          errors++; $display("FAIL tie_d_rdata: got %h expected 12345678", d_rdata);
        end
        d_req = 1'b0;
      end
      if (c == 11) i_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int nvalid;
    logic exp_d;
    nvalid = 0;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step;
      exp_d = (((c - 1) / 4) % 2) == 0;
      if (i_valid || d_valid) nvalid++;
      checks++;
      if (i_valid !== ((c % 4 == 3) && !exp_d) || d_valid !== ((c % 4 == 3) && exp_d)) begin
        errors++; $display("FAIL alternate c%0d: got i=%b d=%b expected i=%b d=%b", c, i_valid, d_valid,
                           ((c % 4 == 3) && !exp_d), ((c % 4 == 3) && exp_d));
      end
      checks++;
      if (mem_en !== (c % 4 == 1 || c % 4 == 2)) begin
        errors++; $display("FAIL alternate_mem_en c%0d: got %b expected %b", c, mem_en, (c % 4 == 1 || c % 4 == 2));
      end
      if (c == 39) begin i_req = 1'b0; d_req = 1'b0; end
    end
    checks++;
    if (nvalid != 10) begin
      errors++; $display("FAIL alternate_count: got %0d expected 10", nvalid);
    end
  endtask

  task automatic test_reset_mid;
    i_req = 1'b1; i_addr = 32'h10;
    step;
    checks++;
    if (mem_en !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got mem_en=%b expected 1", mem_en);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({i_valid, d_valid, mem_en, mem_we} !== 4'b0 || {mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
      errors++; $display("FAIL midrst_outputs: got ctl=%b data=%h expected 0", {i_valid, d_valid, mem_en, mem_we},
                         {mem_addr, mem_wdata, i_rdata, d_rdata});
    end
    #1 rst = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int c = 1; c <= 8; c++) begin
      step;
      if (c == 1) begin
        checks++;
        if (mem_addr !== 32'h10 || mem_en !== 1'b1) begin
          errors++; $display("FAIL midrst_tie_grant: got %h en=%b expected 00000010 en=1", mem_addr, mem_en);
        end
      end
      checks++;
      if (i_valid !== (c == 3) || d_valid !== (c == 7)) begin
        errors++; $display("FAIL midrst_order c%0d: got i=%b d=%b expected i=%b d=%b",
                           c, i_valid, d_valid, (c == 3), (c == 7));
      end
      if (c == 3) i_req = 1'b0;
      if (c == 7) d_req = 1'b0;
    end
  endtask

  task automatic test_lat1;
    l_d_req = 1'b1; l_d_we = 1'b0; l_d_addr = 32'h20;
    for (int c = 1; c <= 3; c++) begin
      step;
      checks++;
      if (l_mem_en !== (c == 1) || l_d_valid !== (c == 2) || l_i_valid !== 1'b0) begin
        errors++; $display("FAIL lat1_timing c%0d: got en=%b dv=%b iv=%b expected en=%b dv=%b iv=0",
                           c, l_mem_en, l_d_valid, l_i_valid, (c == 1), (c == 2));
      end
      if (c == 1) begin
        l_d_addr = 32'h99;
        #2;
        checks++;
        if (l_mem_addr !== 32'h20) begin
          errors++; $display("FAIL lat1_addr_stable: got %h expected 00000020", l_mem_addr);
        end
      end
      if (c == 2) begin
        checks++;
        if (l_d_rdata !== 32'hA500_0020) begin
          errors++; $display("FAIL lat1_rdata: got %h expected a5000020", l_d_rdata);
        end
        l_d_req = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_write_read;
    test_tie;
    test_back_to_back;
    test_reset_mid;
    test_lat1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
